// File: rtl/trace_pkg.sv
// Shared types and sizing helpers for the CPU retire-path trace monitor.
// Imported by the monitor, its trace RAM and the bench.
package trace_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      HALTED  = 2'd2,
      TIMEOUT = 2'd3
   } state_t;

   localparam int ENTRY_ADDR_W  = 8;
   localparam int ENTRY_INSTR_W = 16;

   typedef struct packed {
      logic [ENTRY_ADDR_W-1:0]  pc;
      logic [ENTRY_INSTR_W-1:0] instr;
   } entry_t;

   function automatic int idx_w(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
// A same-address read and write in one cycle returns the old word.
module trace_ram
   import trace_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = 24,
   parameter int AW    = idx_w(DEPTH)
) (
   input  logic             clock,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (we)
         mem[waddr] <= wdata;
   end

   always_ff @(posedge clock) begin
      if (re)
         rdata <= mem[raddr];
   end

endmodule

// File: rtl/cpu_trace_monitor.sv
// Retire-path trace recorder with halt/watchdog status and an
// oldest-first readout port.
module cpu_trace_monitor
   import trace_pkg::*;
#(
   parameter int ADDR_W         = 8,
   parameter int INSTR_W        = 16,
   parameter int DEPTH          = 16,
   parameter int TIMEOUT_CYCLES = 1000,
   localparam int IW            = idx_w(DEPTH),
   localparam int CW            = cnt_w(DEPTH)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      arm,
   input  logic                      wrap_mode,
   input  logic                      retire_valid,
   input  logic [ADDR_W-1:0]         retire_pc,
   input  logic [INSTR_W-1:0]        retire_instr,
   input  logic                      halt,
   input  logic                      rd_en,
   input  logic [IW-1:0]             rd_index,
   output logic                      rd_valid,
   output logic [ADDR_W+INSTR_W-1:0] rd_data,
   output logic [CW-1:0]             count,
   output logic                      wrapped,
   output logic                      busy,
   output logic                      done,
   output logic                      timeout
);

   localparam int DW   = ADDR_W + INSTR_W;
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]   FULL    = CW'(DEPTH);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   state_t          state;
   state_t          state_nxt;
   logic [IW-1:0]   wr_ptr;
   logic [CW-1:0]   cnt;
   logic            wrap_q;
   logic            wrapped_q;
   logic [WD_W-1:0] wdog;
   logic            full;
   logic            run;
   logic            we;
   logic [IW-1:0]   rd_base;
   logic [IW-1:0]   raddr;
   logic            rd_hit;
   logic            rd_ok;
   logic [DW-1:0]   ram_q;

   assign full = (cnt == FULL);
   assign run  = (state == RUN);
   // Arm wins over a same-cycle retire: the fresh run starts empty.
   assign we   = run && retire_valid && !arm && (!full || wrap_q);

   always_comb begin
      state_nxt = state;
      case (state)
         RUN: begin
            if (halt)
               state_nxt = HALTED;
            else if (wdog == WD_LAST)
               state_nxt = TIMEOUT;
         end
         default: ;
      endcase
      if (arm)
         state_nxt = RUN;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         cnt       <= '0;
         wrap_q    <= 1'b0;
         wrapped_q <= 1'b0;
         wdog      <= '0;
      end else begin
         state <= state_nxt;
         if (arm) begin
            wr_ptr    <= '0;
            cnt       <= '0;
            wrapped_q <= 1'b0;
            wdog      <= '0;
            wrap_q    <= wrap_mode;
         end else begin
            if (run)
               wdog <= wdog + 1'b1;
            if (we) begin
               wr_ptr <= wr_ptr + 1'b1;
               if (full)
                  wrapped_q <= 1'b1;
               else
                  cnt <= cnt + 1'b1;
            end
         end
      end
   end

   // Once wrapped, the next write slot holds the oldest entry.
   assign rd_base = wrapped_q ? wr_ptr : '0;
   assign raddr   = rd_base + rd_index;
   assign rd_hit  = ({1'b0, rd_index} < cnt);

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_valid <= 1'b0;
         rd_ok    <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         rd_ok    <= rd_en && rd_hit;
      end
   end

   trace_ram #(
      .DEPTH (DEPTH),
      .WIDTH (DW),
      .AW    (IW)
   ) u_ram (
      .clock (clock),
      .we    (we),
      .waddr (wr_ptr),
      .wdata ({retire_pc, retire_instr}),
      .re    (rd_en),
      .raddr (raddr),
      .rdata (ram_q)
   );

   assign rd_data = rd_ok ? ram_q : '0;
   assign count   = cnt;
   assign wrapped = wrapped_q;
   assign busy    = (state == RUN);
   assign done    = (state == HALTED);
   assign timeout = (state == TIMEOUT);

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Scoreboard bench for cpu_trace_monitor: reads push expected words,
// a negedge monitor pops and compares whenever rd_valid is seen.
module tb_cpu_trace_monitor;
   import trace_pkg::*;

   localparam int DEPTH = 16;
   localparam int TMO   = 100;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        arm = 1'b0;
   logic        wrap_mode = 1'b0;
   logic        retire_valid = 1'b0;
   logic [7:0]  retire_pc = '0;
   logic [15:0] retire_instr = '0;
   logic        halt = 1'b0;
   logic        rd_en = 1'b0;
   logic [3:0]  rd_index = '0;
   logic        rd_valid;
   logic [23:0] rd_data;
   logic [4:0]  count;
   logic        wrapped;
   logic        busy;
   logic        done;
   logic        timeout;

   int checks = 0;
   int failures = 0;
   logic [23:0] exp_q [$];

   always #5 clock = ~clock;

   cpu_trace_monitor #(
      .ADDR_W         (8),
      .INSTR_W        (16),
      .DEPTH          (DEPTH),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .arm          (arm),
      .wrap_mode    (wrap_mode),
      .retire_valid (retire_valid),
      .retire_pc    (retire_pc),
      .retire_instr (retire_instr),
      .halt         (halt),
      .rd_en        (rd_en),
      .rd_index     (rd_index),
      .rd_valid     (rd_valid),
      .rd_data      (rd_data),
      .count        (count),
      .wrapped      (wrapped),
      .busy         (busy),
      .done         (done),
      .timeout      (timeout)
   );

   function automatic logic [23:0] ent(input logic [7:0] pc);
      entry_t e;
      e.pc    = pc;
      e.instr = {8'hA0, pc};
      return e;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      @(negedge clock);
   endtask

   task automatic do_arm(input logic wm);
      arm = 1'b1;
      wrap_mode = wm;
      tick();
      arm = 1'b0;
   endtask

   task automatic retire(input logic [7:0] pc, input logic h);
      retire_valid = 1'b1;
      retire_pc = pc;
      retire_instr = {8'hA0, pc};
      halt = h;
      tick();
      retire_valid = 1'b0;
      halt = 1'b0;
   endtask

   task automatic do_halt();
      halt = 1'b1;
      tick();
      halt = 1'b0;
   endtask

   task automatic rd(input logic [3:0] idx, input logic [23:0] exp);
      rd_en = 1'b1;
      rd_index = idx;
      exp_q.push_back(exp);
      tick();
      rd_en = 1'b0;
   endtask

   task automatic chk_idle_outs(input string nm);
      settle();
      chk({nm, "_count"}, int'(count), 0);
      chk({nm, "_flags"},
          int'({wrapped, busy, done, timeout, rd_valid}), 0);
      chk({nm, "_rd_data"}, int'(rd_data), 0);
   endtask

   always @(negedge clock) begin
      if (!reset && rd_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL rd_unexpected: got %h expected none",
                     rd_data);
         end else begin
            logic [23:0] e;
            e = exp_q.pop_front();
            if (rd_data !== e) begin
               failures++;
               $display("FAIL rd_data: got %h expected %h", rd_data, e);
            end
         end
      end
   end

   initial begin
      int k;
      tick();
      tick();
      chk_idle_outs("reset");
      reset = 1'b0;
      tick();

      // basic capture
      do_arm(1'b1);
      settle();
      chk("arm_busy", int'(busy), 1);
      for (int i = 0; i < 5; i++)
         retire(8'(i), 1'b0);
      do_halt();
      settle();
      chk("basic_done", int'(done), 1);
      chk("basic_busy", int'(busy), 0);
      chk("basic_count", int'(count), 5);
      chk("basic_wrapped", int'(wrapped), 0);
      for (int i = 0; i < 5; i++)
         rd(4'(i), ent(8'(i)));
      rd(4'd5, 24'h0);
      tick();

      // circular overwrite
      do_arm(1'b1);
      for (int i = 0; i < 20; i++)
         retire(8'(i), 1'b0);
      do_halt();
      settle();
      chk("wrap_count", int'(count), 16);
      chk("wrap_wrapped", int'(wrapped), 1);
      rd(4'd0, ent(8'd4));
      rd(4'd15, ent(8'd19));
      tick();

      // stop on full
      do_arm(1'b0);
      for (int i = 0; i < 20; i++)
         retire(8'(i), 1'b0);
      settle();
      chk("stop_busy", int'(busy), 1);
      chk("stop_count", int'(count), 16);
      chk("stop_wrapped", int'(wrapped), 0);
      do_halt();
      rd(4'd15, ent(8'd15));
      rd(4'd0, ent(8'd0));
      tick();

      // halt and retire together
      do_arm(1'b1);
      retire(8'h30, 1'b1);
      settle();
      chk("hr_done", int'(done), 1);
      chk("hr_count", int'(count), 1);
      rd(4'd0, ent(8'h30));
      tick();

      // watchdog expiry timing
      do_arm(1'b1);
      k = 0;
      for (int i = 1; i <= 150; i++) begin
         tick();
         if (timeout) begin
            k = i;
            break;
         end
      end
      chk("tmo_cycles", k, TMO);
      chk("tmo_busy", int'(busy), 0);

      // halt on the expiry cycle
      do_arm(1'b1);
      for (int i = 0; i < TMO - 1; i++)
         tick();
      settle();
      chk("expiry_busy", int'(busy), 1);
      do_halt();
      settle();
      chk("expiry_done", int'(done), 1);
      chk("expiry_timeout", int'(timeout), 0);

      // reset mid-run
      do_arm(1'b1);
      retire(8'h40, 1'b0);
      retire(8'h41, 1'b0);
      reset = 1'b1;
      tick();
      chk_idle_outs("midrst");
      reset = 1'b0;
      tick();

      // re-arm from HALTED
      do_arm(1'b1);
      retire(8'h50, 1'b0);
      retire(8'h51, 1'b0);
      do_halt();
      settle();
      chk("rearm_pre_count", int'(count), 2);
      do_arm(1'b0);
      settle();
      chk("rearm_count", int'(count), 0);
      chk("rearm_busy", int'(busy), 1);
      chk("rearm_done", int'(done), 0);

      tick();
      tick();
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cpu_trace_monitor.md
# cpu_trace_monitor

Synthesizable execution-trace and watchdog block that attaches to the CPU retire path. It records the last DEPTH retired (PC, instruction) pairs in a circular or stop-on-full buffer and detects halt or a cycle-budget timeout. A readout port lets a bench or debug host dump the trace in oldest-first order after the run ends. It generalises the PC logging and timeout safety net into parametrised hardware usable in simulation and on silicon.

## Interface
- ADDR_W, 8, PC width
- INSTR_W, 16, instruction width
- DEPTH, 16, trace entries; power of two, at least 2
- TIMEOUT_CYCLES, 1000, cycle budget from arm to timeout; at least 1
- clock  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high
- arm  in  1  pulse; starts a capture run
- wrap_mode  in  1  1 = circular overwrite, 0 = stop capturing when full; sampled on arm
- retire_valid  in  1  one instruction retired this cycle
- retire_pc  in  ADDR_W  PC of the retired instruction
- retire_instr  in  INSTR_W  retired instruction word
- halt  in  1  CPU executed HLT (level or pulse)
- rd_en  in  1  readout request
- rd_index  in  clog2(DEPTH)  0 = oldest stored entry
- rd_valid  out  1  rd_data valid, one cycle after rd_en
- rd_data  out  ADDR_W+INSTR_W  {pc, instr}
- count  out  clog2(DEPTH)+1  entries held, saturates at DEPTH
- wrapped  out  1  at least one entry overwritten this run
- busy  out  1  state RUN
- done  out  1  state HALTED
- timeout  out  1  state TIMEOUT

## Operation
- States: IDLE, RUN, HALTED, TIMEOUT. Reset puts the block in IDLE.
- IDLE -> RUN on arm. Arm clears write pointer, count, wrapped and the watchdog, and latches wrap_mode.
- RUN: each cycle with retire_valid, writes {retire_pc, retire_instr} at wr_ptr. wr_ptr increments modulo DEPTH, and count increments until it saturates at DEPTH.
- Full with wrap_mode=1: the write overwrites the oldest entry and sets wrapped. Full with wrap_mode=0: the write is dropped, wrapped stays 0 and the state stays RUN.
- RUN -> HALTED when halt=1. A retire_valid in the same cycle is still recorded.
- Watchdog counts RUN cycles starting at 0 on the first RUN cycle. RUN -> TIMEOUT when it reaches TIMEOUT_CYCLES-1 with no halt. If halt and expiry occur in the same cycle, halt wins.
- HALTED and TIMEOUT ignore retire_valid and halt. Any state, including RUN, returns to a fresh run on arm.
- Readout physical index = (wrapped ? wr_ptr : 0) + rd_index, modulo DEPTH.
- rd_index >= count returns rd_data=0, but rd_valid still asserts.
- Reads are allowed in any state. A read in RUN that coincides with a write to the same physical entry returns the old data.
- Outputs after reset: rd_valid=0, rd_data=0, count=0, wrapped=0, busy=0, done=0, timeout=0. The trace RAM contents are not cleared.
- Reset asserted mid-run aborts the run immediately, with no partial status kept.

## Timing
- Capture latency: an entry retired at cycle N counts in `count` from N+1.
- State flags change on the posedge after the causing input: arm → busy next cycle, halt → done next cycle.
- Read latency: exactly 1 cycle, rd_en at N gives rd_valid and rd_data at N+1. Back-to-back reads run at full rate.
- Throughput: one retire per cycle, sustained.

## Structure
- Shared package trace_pkg holds:
  - the state enum (IDLE=0, RUN=1, HALTED=2, TIMEOUT=3)
  - the idx/count width functions
  - the entry struct {pc, instr}
- One sub-module, trace_ram: a simple dual-port, 1-write/1-read synchronous RAM, DEPTH x (ADDR_W+INSTR_W), with registered read.
- Pointer, count, watchdog and FSM logic stay in cpu_trace_monitor.

## Test plan
- Basic capture: reset, arm, 5 retires PC=0x00..0x04, then halt. Required: done=1, count=5, wrapped=0, and rd_index 0..4 returns PC 0x00..0x04 in order.
- Wrap (DEPTH=16, wrap_mode=1): 20 retires PC=0..19. Required: count=16, wrapped=1, rd_index 0 returns PC 4, rd_index 15 returns PC 19.
- Stop-on-full (wrap_mode=0): 20 retires. Required: count=16, wrapped=0, rd_index 15 returns PC 15.
- Timeout (TIMEOUT_CYCLES=100): arm with no halt. Required: timeout rises exactly 100 cycles after busy rose, and busy falls in the same cycle.
- Same-cycle events: halt and retire_valid together → entry recorded and done=1. Halt on the watchdog expiry cycle → done=1, timeout=0.
- Reset and re-arm: reset mid-run → all outputs 0 next cycle. Arm in HALTED → count=0, busy=1.
